// File: rtl/decodificador_seq_param.sv
// decodificador_seq_param: validates a stream of codes against a programmable codebook of NSYM symbols
module decodificador_seq_param #(
  parameter int CODE_W = 7,
  parameter int NSYM = 5,
  parameter logic [NSYM*CODE_W-1:0] CODEBOOK = {7'b1011010, 7'b1101110, 7'b1111100, 7'b1000100, 7'b1100000},
  parameter logic [CODE_W-1:0] TERM_LO = 7'b1001001,
  parameter logic [CODE_W-1:0] TERM_HI = 7'b1010011,
  parameter logic [CODE_W-1:0] ABORT = 7'b1110101,
  parameter int SPLIT = 4,
  parameter int MAX_STEP = 1,
  parameter bit STRICT = 1'b0,
  parameter int MAX_LEN = 0,
  parameter int OUT_W = $clog2(NSYM+1)+1,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic [CODE_W-1:0]       Entrada,
  input  logic                    Controle,
  input  logic                    Limpar,
  input  logic                    Cfg_we,
  input  logic [$clog2(NSYM)-1:0] Cfg_addr,
  input  logic [CODE_W-1:0]       Cfg_code,
  output logic [OUT_W-1:0]        Saida,
  output logic                    Erro,
  output logic                    Fim,
  output logic [LEN_W-1:0]        Passos
);
  localparam int SW = OUT_W-1;
  localparam logic [OUT_W-1:0] E = OUT_W'(1) << (OUT_W-1);
  typedef enum logic [2:0] {S_IDLE, S_SYM, S_ERRO, S_DLO, S_DHI} state_t;
  state_t            r_state, w_state_n;
  logic [SW-1:0]     r_cur, w_cur_n, w_k, w_dist;
  logic [LEN_W-1:0]  r_passos, w_passos_n;
  logic [CODE_W-1:0] r_cb [NSYM];
  logic [OUT_W-1:0]  r_saida, w_saida_n;
  logic              r_erro, r_fim, w_hit, w_far, w_full, w_lo;
  // lowest-index codebook match for the current input code
  always_comb begin
    w_hit = 1'b0;
    w_k = '0;
    for (int i = NSYM-1; i >= 0; i--) begin
      if (r_cb[i] == Entrada) begin
        w_hit = 1'b1;
        w_k = SW'(i+1);
      end
    end
    w_dist = (w_k > r_cur) ? w_k - r_cur : r_cur - w_k;
    w_far = int'(w_dist) > MAX_STEP;
    w_full = (MAX_LEN != 0) && (int'(r_passos) >= MAX_LEN);
    w_lo = int'(r_cur) < SPLIT;
  end
  // next state, current symbol and step count; terminal states only leave via Limpar
  always_comb begin
    w_state_n = r_state;
    w_cur_n = r_cur;
    w_passos_n = r_passos;
    if (Limpar) begin
      w_state_n = S_IDLE;
      w_cur_n = '0;
      w_passos_n = '0;
    end else if (Controle && (r_state == S_IDLE || r_state == S_SYM)) begin
      if (w_hit) begin
        if (r_state == S_IDLE) begin
          w_state_n = S_SYM;
          w_cur_n = w_k;
          w_passos_n = LEN_W'(1);
        end else if (w_k == r_cur) begin
          w_state_n = STRICT ? S_ERRO : r_state;
        end else if (w_far || w_full) begin
          w_state_n = S_ERRO;
        end else begin
          w_cur_n = w_k;
          w_passos_n = r_passos + LEN_W'(r_passos != '1);
        end
      end else if (r_state == S_SYM) begin
        if (Entrada == TERM_LO) w_state_n = w_lo ? S_DLO : S_ERRO;
        else if (Entrada == TERM_HI) w_state_n = w_lo ? S_ERRO : S_DHI;
        else if (Entrada == ABORT) w_state_n = S_ERRO;
      end
    end
    w_saida_n = (w_state_n == S_IDLE) ? '0 :
                (w_state_n == S_SYM)  ? {1'b0, w_cur_n} :
                (w_state_n == S_ERRO) ? E :
                (w_state_n == S_DLO)  ? E + OUT_W'(1) : E + OUT_W'(2);
  end
  // FSM state and registered outputs
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cur <= '0;
      r_passos <= '0;
      r_saida <= '0;
      r_erro <= 1'b0;
      r_fim <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cur <= w_cur_n;
      r_passos <= w_passos_n;
      r_saida <= w_saida_n;
      r_erro <= w_state_n == S_ERRO;
      r_fim <= w_state_n == S_DLO || w_state_n == S_DHI;
    end
  end
  // codebook storage; a write lands at the edge so same-cycle lookups see the old entry
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NSYM; i++) r_cb[i] <= CODEBOOK[i*CODE_W +: CODE_W];
    end else if (Cfg_we && int'(Cfg_addr) < NSYM) begin
      r_cb[Cfg_addr] <= Cfg_code;
    end
  end
  assign Saida = r_saida;
  assign Erro = r_erro;
  assign Fim = r_fim;
  assign Passos = r_passos;
endmodule

// File: tb/tb_decodificador_seq_param.sv
// tb_decodificador_seq_param: scoreboard bench for three parameterisations of the decoder
module tb_decodificador_seq_param;
  localparam logic [6:0] TL = 7'b1001001;
  localparam logic [6:0] TH = 7'b1010011;
  localparam logic [6:0] AB = 7'b1110101;
  localparam logic [6:0] ORIG [5] = '{7'b1100000, 7'b1000100, 7'b1111100, 7'b1101110, 7'b1011010};
  localparam int STRICT_P [3] = '{0, 1, 0};
  localparam int MLEN_P [3] = '{0, 0, 2};
  typedef struct {
    int inst;
    logic [3:0] sa;
    logic er;
    logic fi;
    logic [7:0] pa;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] ent = '0;
  logic ctl = 1'b0;
  logic lim = 1'b0;
  logic we = 1'b0;
  logic [2:0] addr = '0;
  logic [6:0] wcode = '0;
  logic [3:0] sa [3];
  logic er [3];
  logic fi [3];
  logic [7:0] pa [3];
  exp_t q[$];
  int ncmp = 0;
  int nfail = 0;
  int m_sa [3];
  int m_p [3];
  logic [6:0] m_cb [3][5];
  always #5 clk = ~clk;
  decodificador_seq_param u0 (.clk(clk), .Reset(rst), .Entrada(ent), .Controle(ctl), .Limpar(lim),
    .Cfg_we(we), .Cfg_addr(addr), .Cfg_code(wcode), .Saida(sa[0]), .Erro(er[0]), .Fim(fi[0]), .Passos(pa[0]));
  decodificador_seq_param #(.STRICT(1'b1)) u1 (.clk(clk), .Reset(rst), .Entrada(ent), .Controle(ctl), .Limpar(lim),
    .Cfg_we(we), .Cfg_addr(addr), .Cfg_code(wcode), .Saida(sa[1]), .Erro(er[1]), .Fim(fi[1]), .Passos(pa[1]));
  decodificador_seq_param #(.MAX_LEN(2)) u2 (.clk(clk), .Reset(rst), .Entrada(ent), .Controle(ctl), .Limpar(lim),
    .Cfg_we(we), .Cfg_addr(addr), .Cfg_code(wcode), .Saida(sa[2]), .Erro(er[2]), .Fim(fi[2]), .Passos(pa[2]));
  task automatic cmp(input int i, input logic [3:0] s, input logic e, input logic f, input logic [7:0] p, input string tag);
    ncmp++;
    if (sa[i] !== s || er[i] !== e || fi[i] !== f || pa[i] !== p) begin
      nfail++;
      $display("FAIL %s inst%0d t=%0t: got saida=%0d erro=%0b fim=%0b passos=%0d, want saida=%0d erro=%0b fim=%0b passos=%0d",
               tag, i, $time, sa[i], er[i], fi[i], pa[i], s, e, f, p);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sa[i] = 0;
      m_p[i] = 0;
      for (int j = 0; j < 5; j++) m_cb[i][j] = ORIG[j];
    end
  endtask
  // Saida value is the model state: 0 idle, 1..5 symbol, 8 error, 9/10 done
  task automatic model_step(input int i, input logic [6:0] c, input logic ct, input logic l,
                            input logic w, input logic [2:0] a, input logic [6:0] wc);
    int k = 0;
    int d;
    for (int j = 0; j < 5; j++) if (k == 0 && m_cb[i][j] == c) k = j + 1;
    d = k - m_sa[i];
    if (d < 0) d = -d;
    if (l) begin
      m_sa[i] = 0;
      m_p[i] = 0;
    end else if (ct && m_sa[i] <= 5) begin
      if (k != 0) begin
        if (m_sa[i] == 0) begin
          m_sa[i] = k;
          m_p[i] = 1;
        end else if (d == 0) begin
          if (STRICT_P[i] != 0) m_sa[i] = 8;
        end else if (d > 1) m_sa[i] = 8;
        else if (MLEN_P[i] != 0 && m_p[i] + 1 > MLEN_P[i]) m_sa[i] = 8;
        else begin
          m_sa[i] = k;
          if (m_p[i] < 255) m_p[i]++;
        end
      end else if (m_sa[i] != 0) begin
        if (c == TL) m_sa[i] = (m_sa[i] < 4) ? 9 : 8;
        else if (c == TH) m_sa[i] = (m_sa[i] >= 4) ? 10 : 8;
        else if (c == AB) m_sa[i] = 8;
      end
    end
    if (w && a < 5) m_cb[i][a] = wc;
  endtask
  task automatic apply(input logic [6:0] c, input logic ct, input logic l, input logic w,
                       input logic [2:0] a, input logic [6:0] wc);
    ent = c; ctl = ct; lim = l; we = w; addr = a; wcode = wc;
    for (int i = 0; i < 3; i++) begin
      model_step(i, c, ct, l, w, a, wc);
      q.push_back('{i, 4'(m_sa[i]), m_sa[i] == 8, m_sa[i] == 9 || m_sa[i] == 10, 8'(m_p[i])});
    end
  endtask
  task automatic drive(input logic [6:0] c, input logic ct, input logic l, input logic w,
                       input logic [2:0] a, input logic [6:0] wc);
    @(negedge clk);
    apply(c, ct, l, w, a, wc);
  endtask
  task automatic sym(input logic [6:0] c);
    drive(c, 1'b1, 1'b0, 1'b0, 3'd0, 7'd0);
  endtask
  task automatic clr();
    drive(7'd0, 1'b0, 1'b1, 1'b0, 3'd0, 7'd0);
  endtask
  task automatic rst_pulse();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) cmp(i, 4'd0, 1'b0, 1'b0, 8'd0, "async_reset");
    rst = 1'b0;
    apply(7'd0, 1'b0, 1'b0, 1'b0, 3'd0, 7'd0);
  endtask
  function automatic logic [6:0] pick();
    int r = int'($urandom_range(0, 15));
    int c = m_sa[0];
    int idx;
    if (r <= 8) begin
      idx = (c >= 1 && c <= 5) ? c + int'($urandom_range(0, 2)) - 1 : int'($urandom_range(1, 5));
      if (idx < 1) idx = 1;
      if (idx > 5) idx = 5;
      return m_cb[0][idx-1];
    end
    if (r == 9) return m_cb[0][$urandom_range(0, 4)];
    if (r == 10) return TL;
    if (r == 11) return TH;
    if (r == 12) return AB;
    if (r == 15 && c >= 1 && c <= 5) return m_cb[0][c-1];
    return 7'($urandom);
  endfunction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.inst, e.sa, e.er, e.fi, e.pa, "scoreboard");
      end
    end
  end
  initial begin
    logic [6:0] wc;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) cmp(i, 4'd0, 1'b0, 1'b0, 8'd0, "reset");
    rst = 1'b0;
    clr(); sym(ORIG[0]); sym(ORIG[1]); sym(ORIG[2]); sym(TL);
    clr(); sym(ORIG[4]); sym(ORIG[3]); sym(TH); sym(ORIG[0]);
    clr(); sym(ORIG[0]); sym(ORIG[2]); clr();
    clr(); sym(ORIG[4]); sym(TL);
    clr(); sym(ORIG[0]); sym(ORIG[0]);
    clr(); drive(7'd0, 1'b0, 1'b0, 1'b1, 3'd0, 7'b0000001); sym(ORIG[0]); sym(7'b0000001);
    clr(); sym(ORIG[0]); sym(ORIG[1]); sym(ORIG[2]);
    rst_pulse();
    sym(ORIG[0]); sym(ORIG[1]);
    clr(); drive(7'b0000001, 1'b1, 1'b0, 1'b1, 3'd0, 7'b0000001); sym(7'b0000001);
    drive(7'd0, 1'b0, 1'b1, 1'b1, 3'd0, ORIG[0]);
    drive(7'd0, 1'b0, 1'b0, 1'b1, 3'd5, ORIG[1]); sym(ORIG[1]);
    clr(); sym(ORIG[0]);
    for (int n = 0; n < 300; n++) sym(ORIG[(n % 2 == 0) ? 1 : 0]);
    clr();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) rst_pulse();
      else begin
        case ($urandom_range(0, 2))
          0: wc = ORIG[$urandom_range(0, 4)];
          1: wc = ($urandom_range(0, 1) != 0) ? TL : TH;
          default: wc = 7'($urandom);
        endcase
        drive(pick(), $urandom_range(0, 7) != 0,
              (m_sa[0] > 5) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0),
              $urandom_range(0, 15) == 0, 3'($urandom_range(0, 7)), wc);
      end
    end
    repeat (3) @(negedge clk);
    ncmp++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end
endmodule
